// File: rtl/cache_control.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : cache_control
//  Description : Sequencing FSM for a two-way set-associative cache datapath.
//                Accepts one CPU line request at a time. It drives the tag
//                check, hit service, dirty-victim writeback, line allocation
//                and LRU update strobes. It handshakes with physical memory
//                and keeps saturating hit and miss counters.
//
//  Ports       : clk, rst                      clock, synchronous active-high reset
//                mem_read, mem_write, mem_resp CPU request / completion pulse
//                pmem_read, pmem_write,
//                pmem_resp                     physical memory handshake
//                hit0, hit1, valid_bit,
//                dirty_bit, lru_out            datapath status
//                read_array ... dirty_load1    datapath control strobes
//                hit_count, miss_count         saturating event counters
//
//  Revision    : 1.0  initial release
// ============================================================================
module cache_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    input  logic             hit0,
    input  logic             hit1,
    input  logic             valid_bit,
    input  logic             dirty_bit,
    input  logic             lru_out,
    output logic             read_array,
    output logic             write_array,
    output logic             lru_load,
    output logic             data_select,
    output logic             dirty_select,
    output logic             pmem_select,
    output logic [1:0]       write0_select,
    output logic [1:0]       write1_select,
    output logic             valid_load0,
    output logic             valid_load1,
    output logic             tag_load0,
    output logic             tag_load1,
    output logic             dirty_load0,
    output logic             dirty_load1,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam logic [1:0] c_WSEL_NONE = 2'b00;
    localparam logic [1:0] c_WSEL_BYTE = 2'b01;
    localparam logic [1:0] c_WSEL_LINE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_WRITEBACK = 3'd2,
        S_ALLOCATE  = 3'd3,
        S_RELOOKUP  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_refill;     // request already counted as a miss
    logic [CNT_W-1:0] r_hit_count;
    logic [CNT_W-1:0] r_miss_count;
    logic             w_req;
    logic             w_hit;
    logic             w_hit_inc;
    logic             w_miss_inc;

    assign w_req = mem_read | mem_write;
    assign w_hit = hit0 | hit1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_refill     <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next;
            // Set on the first miss so the post-refill CHECK never recounts it.
            if (w_miss_inc)
                r_refill <= 1'b1;
            else if (w_next == S_IDLE)
                r_refill <= 1'b0;
            if (w_hit_inc && (r_hit_count != {CNT_W{1'b1}}))
                r_hit_count <= r_hit_count + CNT_W'(1);
            if (w_miss_inc && (r_miss_count != {CNT_W{1'b1}}))
                r_miss_count <= r_miss_count + CNT_W'(1);
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    always_comb begin
        w_next        = r_state;
        w_hit_inc     = 1'b0;
        w_miss_inc    = 1'b0;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        read_array    = 1'b0;
        write_array   = 1'b0;
        lru_load      = 1'b0;
        data_select   = 1'b0;
        dirty_select  = 1'b0;
        pmem_select   = 1'b0;
        write0_select = c_WSEL_NONE;
        write1_select = c_WSEL_NONE;
        valid_load0   = 1'b0;
        valid_load1   = 1'b0;
        tag_load0     = 1'b0;
        tag_load1     = 1'b0;
        dirty_load0   = 1'b0;
        dirty_load1   = 1'b0;

        case (r_state)
            S_IDLE: begin
                read_array = w_req;
                if (w_req)
                    w_next = S_CHECK;
            end

            S_CHECK: begin
                if (!w_req) begin
                    w_next = S_IDLE;
                end else if (w_hit) begin
                    // A simultaneous read and write is serviced as a write.
                    if (mem_write) begin
                        write_array  = 1'b1;
                        dirty_select = 1'b1;
                        if (hit0) begin
                            write0_select = c_WSEL_BYTE;
                            dirty_load0   = 1'b1;
                        end else begin
                            write1_select = c_WSEL_BYTE;
                            dirty_load1   = 1'b1;
                        end
                    end
                    lru_load  = 1'b1;
                    mem_resp  = 1'b1;
                    w_hit_inc = 1'b1;
                    w_next    = S_IDLE;
                end else begin
                    w_miss_inc = ~r_refill;
                    w_next     = (valid_bit & dirty_bit) ? S_WRITEBACK : S_ALLOCATE;
                end
            end

            S_WRITEBACK: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    // Victim line is now clean in memory.
                    if (lru_out) dirty_load1 = 1'b1;
                    else         dirty_load0 = 1'b1;
                    w_next = S_ALLOCATE;
                end
            end

            S_ALLOCATE: begin
                pmem_read   = 1'b1;
                pmem_select = 1'b1;
                if (pmem_resp) begin
                    data_select = 1'b1;
                    if (lru_out) begin
                        write1_select = c_WSEL_LINE;
                        tag_load1     = 1'b1;
                        valid_load1   = 1'b1;
                        dirty_load1   = 1'b1;
                    end else begin
                        write0_select = c_WSEL_LINE;
                        tag_load0     = 1'b1;
                        valid_load0   = 1'b1;
                        dirty_load0   = 1'b1;
                    end
                    w_next = S_RELOOKUP;
                end
            end

            S_RELOOKUP: begin
                read_array = 1'b1;
                w_next     = S_CHECK;
            end

            default: w_next = S_IDLE;
        endcase

        // Reset dominates: nothing leaves the block while rst is high.
        if (rst) begin
            w_hit_inc     = 1'b0;
            w_miss_inc    = 1'b0;
            mem_resp      = 1'b0;
            pmem_read     = 1'b0;
            pmem_write    = 1'b0;
            read_array    = 1'b0;
            write_array   = 1'b0;
            lru_load      = 1'b0;
            data_select   = 1'b0;
            dirty_select  = 1'b0;
            pmem_select   = 1'b0;
            write0_select = c_WSEL_NONE;
            write1_select = c_WSEL_NONE;
            valid_load0   = 1'b0;
            valid_load1   = 1'b0;
            tag_load0     = 1'b0;
            tag_load1     = 1'b0;
            dirty_load0   = 1'b0;
            dirty_load1   = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_control.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cache_control
//  Description : Scoreboard bench for cache_control with a small two-way,
//                four-set datapath model and a fixed-latency memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_control;

    localparam int CNT_W   = 4;
    localparam int MEM_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
    logic hit0, hit1, valid_bit, dirty_bit, lru_out;
    logic read_array, write_array, lru_load, data_select, dirty_select, pmem_select;
    logic [1:0] write0_select, write1_select;
    logic valid_load0, valid_load1, tag_load0, tag_load1, dirty_load0, dirty_load1;
    logic [CNT_W-1:0] hit_count, miss_count;

    cache_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit0(hit0), .hit1(hit1), .valid_bit(valid_bit), .dirty_bit(dirty_bit),
        .lru_out(lru_out),
        .read_array(read_array), .write_array(write_array), .lru_load(lru_load),
        .data_select(data_select), .dirty_select(dirty_select),
        .pmem_select(pmem_select),
        .write0_select(write0_select), .write1_select(write1_select),
        .valid_load0(valid_load0), .valid_load1(valid_load1),
        .tag_load0(tag_load0), .tag_load1(tag_load1),
        .dirty_load0(dirty_load0), .dirty_load1(dirty_load1),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // ---------------- CPU side and datapath model ----------------
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        m_valid [2][4];
    logic        m_dirty [2][4];
    logic [5:0]  m_tag   [2][4];
    logic [31:0] m_data  [2][4];
    logic        m_lru   [4];
    logic [31:0] pmem    [256];
    logic [31:0] pmem_rdata;
    logic [1:0]  set;
    logic [5:0]  tag;
    logic [7:0]  pm_addr;
    logic [31:0] rdata;

    assign set       = addr[1:0];
    assign tag       = addr[7:2];
    assign hit0      = m_valid[0][set] && (m_tag[0][set] == tag);
    assign hit1      = m_valid[1][set] && (m_tag[1][set] == tag);
    assign lru_out   = m_lru[set];
    assign valid_bit = m_valid[lru_out][set];
    assign dirty_bit = m_dirty[lru_out][set];
    assign pm_addr   = pmem_select ? addr : {m_tag[lru_out][set], set};
    assign rdata     = hit0 ? m_data[0][set] : m_data[1][set];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] en);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            logic [1:0] ws;
            ws = (w == 1) ? write1_select : write0_select;
            if (ws == 2'b10)
                m_data[w][set] <= data_select ? pmem_rdata : wdata;
            else if (ws == 2'b01)
                m_data[w][set] <= merge(m_data[w][set], wdata, be);
        end
        if (tag_load0)   m_tag[0][set]   <= tag;
        if (tag_load1)   m_tag[1][set]   <= tag;
        if (valid_load0) m_valid[0][set] <= 1'b1;
        if (valid_load1) m_valid[1][set] <= 1'b1;
        if (dirty_load0) m_dirty[0][set] <= dirty_select;
        if (dirty_load1) m_dirty[1][set] <= dirty_select;
        if (lru_load)    m_lru[set]      <= hit0;
    end

    // Memory: pmem_resp in the MEM_LAT-th cycle of a request.
    int pcnt = 0;
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (rst || !(pmem_read || pmem_write)) begin
                pcnt = 0; pmem_resp = 1'b0;
            end else begin
                pcnt++;
                if (pcnt == MEM_LAT) begin
                    pcnt = 0; pmem_resp = 1'b1;
                    if (pmem_write) pmem[pm_addr] = m_data[lru_out][set];
                    else            pmem_rdata    = pmem[pm_addr];
                end else begin
                    pmem_resp = 1'b0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          start;
        int          lat;
        logic [31:0] data;
        logic        is_read;
        logic [8:0]  ctrl;
    } exp_t;
    exp_t sbq[$];

    int n_rd, n_wr, n_ov, n_sel_err, n_alloc, n_partial, first_rd, first_wr;
    task automatic clear_stats();
        n_rd = 0; n_wr = 0; n_ov = 0; n_sel_err = 0; n_alloc = 0; n_partial = 0;
        first_rd = -1; first_wr = -1;
    endtask

    logic [8:0]  ctrl;
    logic [18:0] all_outs;
    assign ctrl = {write0_select, write1_select, dirty_load1, dirty_load0,
                   dirty_select, write_array, lru_load};
    assign all_outs = {mem_resp, pmem_read, pmem_write, read_array, write_array, lru_load,
                       data_select, dirty_select, pmem_select, write0_select, write1_select,
                       valid_load0, valid_load1, tag_load0, tag_load1, dirty_load0, dirty_load1};

    // Monitor: per-cycle statistics and scoreboard pops on mem_resp.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pmem_read)  begin n_rd++; if (first_rd < 0) first_rd = cyc; end
                if (pmem_write) begin n_wr++; if (first_wr < 0) first_wr = cyc; end
                if (pmem_read && pmem_write) n_ov++;
                if ((pmem_write && pmem_select) || (pmem_read && !pmem_select)) n_sel_err++;
                if ((tag_load0 && valid_load0 && dirty_load0) ||
                    (tag_load1 && valid_load1 && dirty_load1)) n_alloc++;
                if ((tag_load0 != valid_load0) || (tag_load0 && !dirty_load0) ||
                    (tag_load1 != valid_load1) || (tag_load1 && !dirty_load1)) n_partial++;
                if (mem_resp) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_mem_resp", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("resp_latency", 32'(cyc - e.start), 32'(e.lat));
                        chk("resp_ctrl", 32'(ctrl), 32'(e.ctrl));
                        if (e.is_read) chk("read_data", rdata, e.data);
                    end
                end
            end
        end
    end

    task automatic do_req(input logic [7:0] a, input logic rd, input logic wr,
                          input logic [31:0] wd, input logic [3:0] b, input int lat,
                          input logic [31:0] ed, input logic [8:0] ec);
        exp_t e;
        bit   got;
        clear_stats();
        @(posedge clk); #1;
        addr = a; wdata = wd; be = b; mem_read = rd; mem_write = wr;
        e.start = cyc; e.lat = lat; e.data = ed; e.is_read = rd && !wr; e.ctrl = ec;
        sbq.push_back(e);
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (mem_resp) got = 1'b1;
        end
        if (!got) begin
            chk("mem_resp_timeout", 32'd0, 32'd1);
            void'(sbq.pop_back());
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_counts(input int h, input int m);
        chk("hit_count", 32'(hit_count), 32'(h));
        chk("miss_count", 32'(miss_count), 32'(m));
    endtask

    initial begin
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 4; s++) begin
                m_valid[w][s] = 1'b0; m_dirty[w][s] = 1'b0;
                m_tag[w][s] = '0; m_data[w][s] = '0;
            end
        for (int s = 0; s < 4; s++) m_lru[s] = 1'b0;
        for (int i = 0; i < 256; i++) pmem[i] = 32'hA000_0000 | 32'(i);
        clear_stats();
        addr = '0; wdata = '0; be = '0;
        rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0;   // request held to prove read_array is masked
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(all_outs), 32'd0);
        chk_counts(0, 0);
        @(posedge clk); #1;
        mem_read = 1'b0; rst = 1'b0;

        // Cold clean read miss, set 3, victim way0.
        do_req(8'h0F, 1, 0, 0, 0, 7, 32'hA000_000F, 9'h001);
        chk("cold_pmem_read_cycles", 32'(n_rd), 32'd4);
        chk("cold_pmem_write_cycles", 32'(n_wr), 32'd0);
        chk("cold_alloc_loads", 32'(n_alloc), 32'd1);
        chk("cold_partial_loads", 32'(n_partial), 32'd0);
        chk_counts(1, 1);

        // Repeat read hits without memory traffic.
        do_req(8'h0F, 1, 0, 0, 0, 1, 32'hA000_000F, 9'h001);
        chk("hit_pmem_cycles", 32'(n_rd + n_wr), 32'd0);
        chk_counts(2, 1);

        // Fill way1, then byte-enable write hit on way1.
        do_req(8'h1F, 1, 0, 0, 0, 7, 32'hA000_001F, 9'h001);
        chk_counts(3, 2);
        do_req(8'h1F, 0, 1, 32'h1122_3344, 4'b0011, 1, 0, 9'h037);
        chk_counts(4, 2);
        do_req(8'h1F, 1, 0, 0, 0, 1, 32'hA000_3344, 9'h001);
        do_req(8'h0F, 1, 0, 0, 0, 1, 32'hA000_000F, 9'h001);   // LRU now points at way1
        chk_counts(6, 2);

        // Dirty victim way1: writeback then allocate.
        do_req(8'h2F, 1, 0, 0, 0, 11, 32'hA000_002F, 9'h001);
        chk("dirty_pmem_write_cycles", 32'(n_wr), 32'd4);
        chk("dirty_pmem_read_cycles", 32'(n_rd), 32'd4);
        chk("dirty_overlap", 32'(n_ov), 32'd0);
        chk("dirty_order", 32'(first_wr < first_rd), 32'd1);
        chk("dirty_pmem_select", 32'(n_sel_err), 32'd0);
        chk("writeback_data", pmem[8'h1F], 32'hA000_3344);
        chk_counts(7, 3);

        // Reset while allocating (victim way0 is clean).
        clear_stats();
        @(posedge clk); #1;
        addr = 8'h33; mem_read = 1'b1;
        for (int n = 0; n < 40 && n_rd < 2; n++) @(negedge clk);
        chk("alloc_reached", 32'(n_rd), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pmem_read", 32'(pmem_read), 32'd0);
        chk("rst_outputs", 32'(all_outs), 32'd0);
        @(negedge clk);
        chk("rst_outputs_2", 32'(all_outs), 32'd0);
        chk_counts(0, 0);
        @(posedge clk); #1;
        mem_read = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("abandoned_not_resumed", 32'(pmem_read | pmem_write), 32'd0);

        // Read and write together act as a write (hit way0).
        do_req(8'h0F, 1, 1, 32'h5566_7788, 4'b1000, 1, 0, 9'h08F);
        chk_counts(1, 0);
        do_req(8'h0F, 1, 0, 0, 0, 1, 32'h5500_000F, 9'h001);

        // Saturation of the hit counter.
        for (int i = 0; i < 13; i++)
            do_req(8'h0F, 1, 0, 0, 0, 1, 32'h5500_000F, 9'h001);
        chk_counts(15, 0);
        do_req(8'h0F, 1, 0, 0, 0, 1, 32'h5500_000F, 9'h001);
        chk_counts(15, 0);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
